// File: rtl/neural_stream_packer_pkg.sv
// Shared definitions for the neural-data stream path: packer state encoding
// and the default sample and host word widths.
package rhythm_pkg;

    localparam int DEFAULT_IN_W  = 16;
    localparam int DEFAULT_OUT_W = 32;

    typedef enum logic [1:0] {
        WAIT_SYNC = 2'd0,
        PACK      = 2'd1,
        OVERFLOW  = 2'd2
    } packer_state_t;

endpackage

// File: rtl/neural_stream_packer_sync_fifo.sv
// Single-clock FIFO with a registered read port and an occupancy output.
// Pointers are one bit narrower than the level counter and wrap naturally
// because DEPTH is a power of two.
module sync_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 2048
) (
    input  logic                     clk,
    input  logic                     clear,
    input  logic                     wr_en,
    input  logic [W-1:0]             wr_data,
    input  logic                     rd_en,
    output logic [W-1:0]             rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [W-1:0]  rd_q;
    logic          do_wr;
    logic          do_rd;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_wr   = wr_en & ~full;
    assign do_rd   = rd_en & ~empty;
    assign rd_data = rd_q;
    assign level   = count;

    // Storage array: written only when not clearing and not full.
    always_ff @(posedge clk) begin
        if (do_wr && !clear) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers, occupancy and the registered read word; clear wins over everything.
    always_ff @(posedge clk) begin
        if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rd_q   <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
                rd_q   <= mem[rd_ptr];
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/neural_stream_packer.sv
// Packs IN_W-bit amplifier samples into OUT_W-bit host words, buffers them in a
// FIFO and presents the host read-pipe handshake. Packing starts only on a
// frame-start word, a FIFO overflow freezes the packer until the pipe is
// closed or reset, and input words lost during overflow are counted.
module neural_stream_packer
    import rhythm_pkg::*;
#(
    parameter int IN_W   = DEFAULT_IN_W,
    parameter int OUT_W  = DEFAULT_OUT_W,
    parameter int DEPTH  = 2048,
    parameter int DROP_W = 16
) (
    input  logic                     bus_clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [IN_W-1:0]          in_data,
    input  logic                     in_frame_start,
    input  logic                     swap_en,
    input  logic                     rd_open,
    input  logic                     rd_en,
    output logic [OUT_W-1:0]         rd_data,
    output logic                     rd_empty,
    output logic                     rd_eof,
    output logic                     overflow,
    output logic [DROP_W-1:0]        drop_count,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int RATIO  = OUT_W / IN_W;
    localparam int LANE_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);

    packer_state_t     state;
    logic [LANE_W-1:0] lane;
    logic [LANE_W-1:0] k_eff;
    logic [OUT_W-1:0]  pack_reg;
    logic [OUT_W-1:0]  assembled;
    logic              push_valid;
    logic              clear;
    logic              fifo_full;
    logic              fifo_empty;
    logic              ovf_now;
    logic              accept;
    logic              last_lane;
    logic              dropping;
    int                phys;

    assign clear    = reset | ~rd_open;
    assign ovf_now  = push_valid & fifo_full;
    assign dropping = ovf_now | (state == OVERFLOW);
    assign rd_empty = fifo_empty;
    assign rd_eof   = overflow & fifo_empty;

    // Lane selection and word assembly for the sample arriving this cycle;
    // a frame-start sample always restarts the group at logical lane 0.
    always_comb begin
        k_eff     = in_frame_start ? '0 : lane;
        phys      = swap_en ? (RATIO - 1 - int'(k_eff)) : int'(k_eff);
        assembled = pack_reg;
        for (int i = 0; i < RATIO; i++) begin
            if (i == phys) begin
                assembled[i*IN_W +: IN_W] = in_data;
            end
        end
        last_lane = (k_eff == LAST_LANE);
        accept    = in_valid & ~ovf_now &
                    ((state == PACK) | ((state == WAIT_SYNC) & in_frame_start));
    end

    // Packer FSM with the lane counter, push stage, sticky overflow and drop counter.
    always_ff @(posedge bus_clk) begin
        if (clear) begin
            state      <= WAIT_SYNC;
            lane       <= '0;
            pack_reg   <= '0;
            push_valid <= 1'b0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            push_valid <= 1'b0;
            if (ovf_now) begin
                state    <= OVERFLOW;
                overflow <= 1'b1;
            end
            if (dropping) begin
                if (in_valid && (drop_count != '1)) begin
                    drop_count <= drop_count + 1'b1;
                end
            end else if (accept) begin
                pack_reg <= assembled;
                state    <= PACK;
                if (last_lane) begin
                    lane       <= '0;
                    push_valid <= 1'b1;
                end else begin
                    lane <= k_eff + 1'b1;
                end
            end
        end
    end

    sync_fifo #(
        .W     (OUT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (bus_clk),
        .clear   (clear),
        .wr_en   (push_valid),
        .wr_data (pack_reg),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .level   (level)
    );

endmodule

// File: tb/tb_neural_stream_packer.sv
// Bench for neural_stream_packer: a default instance, a shallow FIFO instance
// with a narrow drop counter, and a 4:1 packing instance share the stimulus.
module tb_neural_stream_packer;

    logic        bus_clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_frame_start;
    logic        swap_en;
    logic        rd_open;
    logic        rd_en;

    logic [31:0] rd_data_a;
    logic        rd_empty_a, rd_eof_a, overflow_a;
    logic [15:0] drop_a;
    logic [11:0] level_a;

    logic [31:0] rd_data_s;
    logic        rd_empty_s, rd_eof_s, overflow_s;
    logic [3:0]  drop_s;
    logic [2:0]  level_s;

    logic [63:0] rd_data_w;
    logic        rd_empty_w, rd_eof_w, overflow_w;
    logic [15:0] drop_w;
    logic [3:0]  level_w;

    int checks = 0;
    int passes = 0;

    always #5 bus_clk = ~bus_clk;

    neural_stream_packer dut (
        .bus_clk(bus_clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_frame_start(in_frame_start), .swap_en(swap_en), .rd_open(rd_open), .rd_en(rd_en),
        .rd_data(rd_data_a), .rd_empty(rd_empty_a), .rd_eof(rd_eof_a), .overflow(overflow_a),
        .drop_count(drop_a), .level(level_a)
    );

    neural_stream_packer #(.DEPTH(4), .DROP_W(4)) dut_small (
        .bus_clk(bus_clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_frame_start(in_frame_start), .swap_en(swap_en), .rd_open(rd_open), .rd_en(rd_en),
        .rd_data(rd_data_s), .rd_empty(rd_empty_s), .rd_eof(rd_eof_s), .overflow(overflow_s),
        .drop_count(drop_s), .level(level_s)
    );

    neural_stream_packer #(.OUT_W(64), .DEPTH(8)) dut_wide (
        .bus_clk(bus_clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_frame_start(in_frame_start), .swap_en(swap_en), .rd_open(rd_open), .rd_en(rd_en),
        .rd_data(rd_data_w), .rd_empty(rd_empty_w), .rd_eof(rd_eof_w), .overflow(overflow_w),
        .drop_count(drop_w), .level(level_w)
    );

    task automatic tick();
        @(posedge bus_clk);
        #1;
    endtask

    task automatic send_word(input logic [15:0] d, input logic fs);
        in_valid = 1'b1;
        in_data = d;
        in_frame_start = fs;
        tick();
        in_valid = 1'b0;
        in_frame_start = 1'b0;
    endtask

    task automatic clear_all(input logic swap);
        rd_en = 1'b0;
        in_valid = 1'b0;
        in_frame_start = 1'b0;
        rd_open = 1'b0;
        swap_en = swap;
        tick();
        rd_open = 1'b1;
    endtask

    task automatic pop();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic wait_a();
        for (int i = 0; i < 6 && rd_empty_a === 1'b1; i++) tick();
    endtask

    task automatic fill_small_five();
        for (int g = 0; g < 5; g++) begin
            send_word(16'(32'h1000 + 2 * g), (g == 0));
            send_word(16'(32'h1001 + 2 * g), 1'b0);
        end
        tick();
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        rd_open = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_frame_start = 1'b1;
            in_data = 16'($urandom);
            tick();
        end
        in_valid = 1'b0;
        in_frame_start = 1'b0;
        checks++; if (rd_empty_a !== 1'b1) $display("[TB] FAIL reset_empty: got %b expected 1", rd_empty_a); else passes++;
        checks++; if (level_a !== 12'd0) $display("[TB] FAIL reset_level: got %0d expected 0", level_a); else passes++;
        checks++; if (overflow_a !== 1'b0) $display("[TB] FAIL reset_overflow: got %b expected 0", overflow_a); else passes++;
        checks++; if (drop_a !== 16'd0) $display("[TB] FAIL reset_drop: got %0d expected 0", drop_a); else passes++;
        checks++; if (rd_data_a !== 32'd0) $display("[TB] FAIL reset_rd_data: got %h expected 0", rd_data_a); else passes++;
        checks++; if (rd_eof_a !== 1'b0) $display("[TB] FAIL reset_eof: got %b expected 0", rd_eof_a); else passes++;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_pack_basic(input logic swap, input logic [31:0] expected);
        clear_all(swap);
        send_word(16'h1111, 1'b1);
        send_word(16'h2222, 1'b0);
        checks++; if (rd_empty_a !== 1'b1) $display("[TB] FAIL push_stage_empty: got %b expected 1", rd_empty_a); else passes++;
        wait_a();
        checks++; if (rd_empty_a !== 1'b0) $display("[TB] FAIL basic_nonempty: got %b expected 0", rd_empty_a); else passes++;
        checks++; if (level_a !== 12'd1) $display("[TB] FAIL basic_level: got %0d expected 1", level_a); else passes++;
        rd_en = 1'b1;
        checks++; if (rd_data_a !== 32'd0) $display("[TB] FAIL basic_data_before_pop: got %h expected 0", rd_data_a); else passes++;
        tick();
        rd_en = 1'b0;
        checks++; if (rd_data_a !== expected) $display("[TB] FAIL basic_word swap=%b: got %h expected %h", swap, rd_data_a, expected); else passes++;
        tick();
        checks++; if (rd_empty_a !== 1'b1 || level_a !== 12'd0) $display("[TB] FAIL basic_drained: got empty=%b level=%0d expected 1/0", rd_empty_a, level_a); else passes++;
        pop();
        checks++; if (rd_data_a !== expected) $display("[TB] FAIL empty_read_hold: got %h expected %h", rd_data_a, expected); else passes++;
    endtask

    task automatic test_ratio4(input logic swap, input logic [63:0] expected);
        clear_all(swap);
        for (int i = 1; i <= 4; i++) send_word(16'(i), (i == 1));
        for (int i = 0; i < 6 && rd_empty_w === 1'b1; i++) tick();
        checks++; if (level_w !== 4'd1) $display("[TB] FAIL ratio4_level: got %0d expected 1", level_w); else passes++;
        pop();
        checks++; if (rd_data_w !== expected) $display("[TB] FAIL ratio4_word swap=%b: got %h expected %h", swap, rd_data_w, expected); else passes++;
        checks++; if (overflow_w !== 1'b0 || drop_w !== 16'd0 || rd_eof_w !== 1'b0)
            $display("[TB] FAIL ratio4_flags: got ovf=%b drop=%0d eof=%b expected 0/0/0", overflow_w, drop_w, rd_eof_w); else passes++;
    endtask

    task automatic test_no_sync();
        clear_all(1'b0);
        send_word(16'hAAAA, 1'b0);
        send_word(16'hBBBB, 1'b0);
        tick(); tick(); tick();
        checks++; if (rd_empty_a !== 1'b1 || level_a !== 12'd0) $display("[TB] FAIL nosync_discard: got empty=%b level=%0d expected 1/0", rd_empty_a, level_a); else passes++;
        send_word(16'h0001, 1'b1);
        send_word(16'h0002, 1'b0);
        wait_a();
        checks++; if (level_a !== 12'd1) $display("[TB] FAIL nosync_level: got %0d expected 1", level_a); else passes++;
        pop();
        checks++; if (rd_data_a !== 32'h0002_0001) $display("[TB] FAIL nosync_word: got %h expected 00020001", rd_data_a); else passes++;
    endtask

    task automatic test_overflow();
        clear_all(1'b0);
        fill_small_five();
        checks++; if (level_s !== 3'd4) $display("[TB] FAIL ovf_level: got %0d expected 4", level_s); else passes++;
        checks++; if (overflow_s !== 1'b1) $display("[TB] FAIL ovf_flag: got %b expected 1", overflow_s); else passes++;
        checks++; if (drop_s !== 4'd0 || rd_eof_s !== 1'b0) $display("[TB] FAIL ovf_pre_drop: got drop=%0d eof=%b expected 0/0", drop_s, rd_eof_s); else passes++;
        for (int i = 0; i < 3; i++) send_word(16'hDEAD, (i == 0));
        checks++; if (drop_s !== 4'd3) $display("[TB] FAIL ovf_drop3: got %0d expected 3", drop_s); else passes++;
        for (int g = 0; g < 4; g++) begin
            pop();
            checks++;
            if (rd_data_s !== {16'(32'h1001 + 2 * g), 16'(32'h1000 + 2 * g)})
                $display("[TB] FAIL ovf_read%0d: got %h expected %h", g, rd_data_s, {16'(32'h1001 + 2 * g), 16'(32'h1000 + 2 * g)});
            else passes++;
            if (g < 3) begin
                checks++; if (rd_eof_s !== 1'b0) $display("[TB] FAIL ovf_eof_early%0d: got %b expected 0", g, rd_eof_s); else passes++;
            end
        end
        checks++; if (rd_eof_s !== 1'b1 || rd_empty_s !== 1'b1) $display("[TB] FAIL ovf_eof: got eof=%b empty=%b expected 1/1", rd_eof_s, rd_empty_s); else passes++;
        for (int i = 0; i < 20; i++) send_word(16'(i), 1'b0);
        checks++; if (drop_s !== 4'hF) $display("[TB] FAIL drop_saturate: got %0d expected 15", drop_s); else passes++;
    endtask

    task automatic test_mid_group_frame();
        clear_all(1'b0);
        send_word(16'h0A0A, 1'b1);
        send_word(16'h0B0B, 1'b1);
        send_word(16'h0C0C, 1'b0);
        wait_a();
        tick();
        checks++; if (level_a !== 12'd1 || drop_a !== 16'd0) $display("[TB] FAIL midgroup_level_drop: got level=%0d drop=%0d expected 1/0", level_a, drop_a); else passes++;
        pop();
        checks++; if (rd_data_a !== 32'h0C0C_0B0B) $display("[TB] FAIL midgroup_word: got %h expected 0c0c0b0b", rd_data_a); else passes++;
    endtask

    task automatic test_clear();
        clear_all(1'b0);
        fill_small_five();
        pop();
        checks++; if (level_s !== 3'd3 || overflow_s !== 1'b1) $display("[TB] FAIL clear_setup: got level=%0d ovf=%b expected 3/1", level_s, overflow_s); else passes++;
        rd_open = 1'b0;
        tick();
        checks++; if (level_s !== 3'd0 || overflow_s !== 1'b0) $display("[TB] FAIL clear_state: got level=%0d ovf=%b expected 0/0", level_s, overflow_s); else passes++;
        checks++; if (rd_empty_s !== 1'b1 || rd_eof_s !== 1'b0 || drop_s !== 4'd0 || rd_data_s !== 32'd0)
            $display("[TB] FAIL clear_outputs: got empty=%b eof=%b drop=%0d data=%h expected 1/0/0/0", rd_empty_s, rd_eof_s, drop_s, rd_data_s); else passes++;
        rd_open = 1'b1;
        send_word(16'h5555, 1'b0);
        send_word(16'h6666, 1'b0);
        tick(); tick(); tick();
        checks++; if (rd_empty_s !== 1'b1) $display("[TB] FAIL clear_wait_sync: got empty=%b expected 1", rd_empty_s); else passes++;
        clear_all(1'b0);
        send_word(16'h0001, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        send_word(16'h0002, 1'b0);
        send_word(16'h0003, 1'b1);
        send_word(16'h0004, 1'b0);
        wait_a();
        tick();
        checks++; if (level_a !== 12'd1) $display("[TB] FAIL reset_midgroup_level: got %0d expected 1", level_a); else passes++;
        pop();
        checks++; if (rd_data_a !== 32'h0004_0003) $display("[TB] FAIL reset_midgroup_word: got %h expected 00040003", rd_data_a); else passes++;
    endtask

    task automatic test_random_stream();
        logic [31:0] exp_q[$];
        logic [15:0] lanes [2];
        logic [31:0] w;
        logic        synced;
        logic        swap, v, fs, rd;
        logic [15:0] d;
        int          k;
        synced = 1'b0;
        k = 0;
        swap = 1'($urandom % 2);
        clear_all(swap);
        for (int c = 0; c < 500; c++) begin
            v  = (($urandom % 2) == 1);
            fs = (($urandom % 5) == 0);
            d  = 16'($urandom);
            rd = (rd_empty_a === 1'b0) && (($urandom % 3) != 0);
            in_valid = v; in_frame_start = fs; in_data = d; rd_en = rd;
            if (v) begin
                if (fs) begin synced = 1'b1; k = 0; end
                if (synced) begin
                    lanes[k] = d;
                    k++;
                    if (k == 2) begin
                        w = swap ? {lanes[0], lanes[1]} : {lanes[1], lanes[0]};
                        exp_q.push_back(w);
                        k = 0;
                    end
                end
            end
            tick();
            if (rd) begin
                checks++;
                if (exp_q.size() == 0) $display("[TB] FAIL rand_pop_unexpected: got %h expected no word", rd_data_a);
                else begin
                    w = exp_q.pop_front();
                    if (rd_data_a !== w) $display("[TB] FAIL rand_word: got %h expected %h", rd_data_a, w); else passes++;
                end
            end
        end
        in_valid = 1'b0; in_frame_start = 1'b0;
        for (int c = 0; c < 30; c++) begin
            rd = (rd_empty_a === 1'b0);
            rd_en = rd;
            tick();
            if (rd) begin
                checks++;
                if (exp_q.size() == 0) $display("[TB] FAIL rand_drain_unexpected: got %h expected no word", rd_data_a);
                else begin
                    w = exp_q.pop_front();
                    if (rd_data_a !== w) $display("[TB] FAIL rand_drain_word: got %h expected %h", rd_data_a, w); else passes++;
                end
            end
        end
        rd_en = 1'b0;
        checks++; if (exp_q.size() != 0 || rd_empty_a !== 1'b1) $display("[TB] FAIL rand_leftover: got %0d model words empty=%b expected 0/1", exp_q.size(), rd_empty_a); else passes++;
    endtask

    task automatic test_random_overflow();
        logic [31:0] exp_q[$];
        logic [15:0] lanes [2];
        logic [31:0] w;
        logic        synced, ovf, swap, v, fs;
        logic [15:0] d;
        int          k, drops;
        synced = 1'b0; ovf = 1'b0; k = 0; drops = 0;
        swap = 1'($urandom % 2);
        clear_all(swap);
        for (int c = 0; c < 80; c++) begin
            v  = (($urandom % 4) != 0);
            fs = (($urandom % 8) == 0);
            d  = 16'($urandom);
            in_valid = v; in_frame_start = fs; in_data = d;
            if (v) begin
                if (ovf) begin
                    if (drops < 15) drops++;
                end else begin
                    if (fs) begin synced = 1'b1; k = 0; end
                    if (synced) begin
                        lanes[k] = d;
                        k++;
                        if (k == 2) begin
                            w = swap ? {lanes[0], lanes[1]} : {lanes[1], lanes[0]};
                            if (exp_q.size() < 4) exp_q.push_back(w); else ovf = 1'b1;
                            k = 0;
                        end
                    end
                end
            end
            tick();
        end
        in_valid = 1'b0; in_frame_start = 1'b0;
        tick(); tick(); tick();
        checks++; if (overflow_s !== ovf) $display("[TB] FAIL rovf_flag: got %b expected %b", overflow_s, ovf); else passes++;
        checks++; if (drop_s !== 4'(drops)) $display("[TB] FAIL rovf_drop: got %0d expected %0d", drop_s, drops); else passes++;
        checks++; if (level_s !== 3'(exp_q.size())) $display("[TB] FAIL rovf_level: got %0d expected %0d", level_s, exp_q.size()); else passes++;
        while (exp_q.size() != 0) begin
            w = exp_q.pop_front();
            pop();
            checks++; if (rd_data_s !== w) $display("[TB] FAIL rovf_word: got %h expected %h", rd_data_s, w); else passes++;
        end
        checks++; if (rd_eof_s !== ovf || rd_empty_s !== 1'b1) $display("[TB] FAIL rovf_eof: got eof=%b empty=%b expected %b/1", rd_eof_s, rd_empty_s, ovf); else passes++;
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_frame_start = 1'b0;
        swap_en = 1'b0; rd_open = 1'b1; rd_en = 1'b0;
        test_reset();
        test_pack_basic(1'b0, 32'h2222_1111);
        test_pack_basic(1'b1, 32'h1111_2222);
        test_ratio4(1'b0, 64'h0004_0003_0002_0001);
        test_ratio4(1'b1, 64'h0001_0002_0003_0004);
        test_no_sync();
        test_overflow();
        test_mid_group_frame();
        test_clear();
        test_random_stream();
        test_random_overflow();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
